// File: rtl/rr_dispatcher_if.sv
// rtl/rr_dispatcher_if.sv - upstream stream, downstream ports and status of the round-robin dispatcher
interface rr_dispatcher_if #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 8
);
   logic                             up_valid;
   logic [DATA_WIDTH-1:0]            up_data;
   logic                             up_last;
   logic                             up_ready;
   logic [NUM_PORTS-1:0]             port_enable;
   logic [NUM_PORTS-1:0]             dn_valid;
   logic [NUM_PORTS*DATA_WIDTH-1:0]  dn_data;
   logic [NUM_PORTS-1:0]             dn_last;
   logic [NUM_PORTS-1:0]             dn_ready;
   logic                             busy;

   modport master (
      output up_valid, up_data, up_last, port_enable, dn_ready,
      input  up_ready, dn_valid, dn_data, dn_last, busy
   );

   modport slave (
      input  up_valid, up_data, up_last, port_enable, dn_ready,
      output up_ready, dn_valid, dn_data, dn_last, busy
   );
endinterface

// File: rtl/rr_dispatcher.sv
// rtl/rr_dispatcher.sv - round-robin packet dispatcher from one stream to NUM_PORTS single-entry ports
module rr_dispatcher #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 8
) (
   input logic            clk,
   input logic            rst,
   rr_dispatcher_if.slave bus
);
   localparam int               IDX_W    = $clog2(NUM_PORTS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PORTS - 1);
   localparam logic [IDX_W:0]   NP       = (IDX_W+1)'(NUM_PORTS);

   typedef enum logic {IDLE, LOCKED} state_t;

   state_t                          state_q, state_d;
   logic [NUM_PORTS-1:0]            token_q, token_d;
   logic [IDX_W-1:0]                lock_q, lock_d;
   logic [NUM_PORTS-1:0]            dn_valid_q, dn_valid_d;
   logic [NUM_PORTS-1:0]            dn_last_q;
   logic [NUM_PORTS*DATA_WIDTH-1:0] dn_data_q;
   logic                            busy_q, busy_d;

   logic [NUM_PORTS-1:0] free, cand, wr_vec;
   logic [IDX_W-1:0]     tok_idx, sel_idx, wr_idx, next_idx;
   logic [IDX_W:0]       pos;
   logic                 up_ready, xfer;

   function automatic logic [IDX_W-1:0] inc_idx(input logic [IDX_W-1:0] idx);
      return (idx == LAST_IDX) ? '0 : idx + 1'b1;
   endfunction

   // A port draining this cycle can be refilled in the same cycle
   assign free = ~dn_valid_q | bus.dn_ready;
   assign cand = bus.port_enable & free;

   always_comb begin : find_token
      tok_idx = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (token_q[i]) tok_idx = IDX_W'(i);
      end
   end

   // Descending scan so the candidate closest above the token wins
   always_comb begin : select_port
      sel_idx = tok_idx;
      pos     = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         pos = {1'b0, tok_idx} + (IDX_W+1)'(k);
         if (pos >= NP) pos = pos - NP;
         if (cand[pos[IDX_W-1:0]]) sel_idx = pos[IDX_W-1:0];
      end
   end

   always_comb begin : fsm_next
      state_d  = state_q;
      token_d  = token_q;
      lock_d   = lock_q;
      up_ready = 1'b0;
      wr_idx   = sel_idx;
      case (state_q)
         IDLE: begin
            up_ready = |cand;
            wr_idx   = sel_idx;
         end
         LOCKED: begin
            up_ready = free[lock_q];
            wr_idx   = lock_q;
         end
         default: ;
      endcase
      xfer     = bus.up_valid & up_ready;
      next_idx = inc_idx(wr_idx);
      if (xfer) begin
         if (bus.up_last) begin
            token_d = NUM_PORTS'(1) << next_idx;
            state_d = IDLE;
         end else begin
            lock_d  = wr_idx;
            state_d = LOCKED;
         end
      end
   end

   always_comb begin : port_next
      wr_vec     = xfer ? (NUM_PORTS'(1) << wr_idx) : '0;
      dn_valid_d = (dn_valid_q & ~bus.dn_ready) | wr_vec;
      busy_d     = (state_d == LOCKED) | (|dn_valid_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         token_q    <= NUM_PORTS'(1);
         lock_q     <= '0;
         dn_valid_q <= '0;
         dn_last_q  <= '0;
         dn_data_q  <= '0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         token_q    <= token_d;
         lock_q     <= lock_d;
         dn_valid_q <= dn_valid_d;
         busy_q     <= busy_d;
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (wr_vec[i]) begin
               dn_data_q[i*DATA_WIDTH +: DATA_WIDTH] <= bus.up_data;
               dn_last_q[i]                          <= bus.up_last;
            end
         end
      end
   end

   assign bus.up_ready = up_ready;
   assign bus.dn_valid = dn_valid_q;
   assign bus.dn_data  = dn_data_q;
   assign bus.dn_last  = dn_last_q;
   assign bus.busy     = busy_q;
endmodule

// File: tb/tb_rr_dispatcher.sv
// tb/tb_rr_dispatcher.sv - directed bench for the round-robin dispatcher
module tb_rr_dispatcher;
   logic clk;
   logic rst;
   int   checks;
   int   errors;
   int   port;
   logic [7:0] d;
   logic [3:0] exp_v;

   rr_dispatcher_if #(.NUM_PORTS(4), .DATA_WIDTH(8)) bus ();

   rr_dispatcher #(.NUM_PORTS(4), .DATA_WIDTH(8)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.up_valid = 1'b0; bus.up_data = 8'h00; bus.up_last = 1'b0;
      bus.port_enable = 4'b0000; bus.dn_ready = 4'b0000;
      step(); step();
      rst = 1'b0;
      #1;
      checks++; if (bus.dn_valid !== 4'b0000) begin errors++; $display("FAIL reset_dn_valid got %b expected 0000", bus.dn_valid); end
      checks++; if (bus.dn_last !== 4'b0000) begin errors++; $display("FAIL reset_dn_last got %b expected 0000", bus.dn_last); end
      checks++; if (bus.dn_data !== 32'h0) begin errors++; $display("FAIL reset_dn_data got %h expected 0", bus.dn_data); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
      checks++; if (dut.token_q !== 4'b0001) begin errors++; $display("FAIL reset_token got %b expected 0001", dut.token_q); end
      checks++; if (bus.up_ready !== 1'b0) begin errors++; $display("FAIL reset_up_ready got %b expected 0", bus.up_ready); end
   endtask

   task automatic test_single_beat();
      bus.port_enable = 4'b1111; bus.dn_ready = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         d = 8'((k + 1) * 17);
         port = k % 4;
         exp_v = 4'b0001 << port;
         bus.up_valid = 1'b1; bus.up_data = d; bus.up_last = 1'b1;
         #1;
         checks++; if (bus.up_ready !== 1'b1) begin errors++; $display("FAIL single_up_ready[%0d] got %b expected 1", k, bus.up_ready); end
         step();
         checks++; if (bus.dn_valid !== exp_v) begin errors++; $display("FAIL single_dn_valid[%0d] got %b expected %b", k, bus.dn_valid, exp_v); end
         checks++; if (bus.dn_data[port*8 +: 8] !== d) begin errors++; $display("FAIL single_dn_data[%0d] got %h expected %h", k, bus.dn_data[port*8 +: 8], d); end
         checks++; if (bus.dn_last[port] !== 1'b1) begin errors++; $display("FAIL single_dn_last[%0d] got %b expected 1", k, bus.dn_last[port]); end
      end
      bus.up_valid = 1'b0;
      step();
      checks++; if (bus.dn_valid !== 4'b0000) begin errors++; $display("FAIL single_drain got %b expected 0000", bus.dn_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL single_busy got %b expected 0", bus.busy); end
   endtask

   task automatic test_skip_held();
      // Go around once with port 1 stuck so the token returns to 1 while port 1 is held
      bus.dn_ready = 4'b1101;
      for (int k = 0; k < 4; k++) begin
         port = (1 + k) % 4;
         bus.up_valid = 1'b1; bus.up_data = 8'(8'h60 + port); bus.up_last = 1'b1;
         step();
      end
      bus.up_data = 8'hA0;
      #1;
      checks++; if (bus.up_ready !== 1'b1) begin errors++; $display("FAIL skip_up_ready got %b expected 1", bus.up_ready); end
      step();
      checks++; if (bus.dn_valid !== 4'b0110) begin errors++; $display("FAIL skip_a0_valid got %b expected 0110", bus.dn_valid); end
      checks++; if (bus.dn_data[23:16] !== 8'hA0) begin errors++; $display("FAIL skip_a0_data got %h expected a0", bus.dn_data[23:16]); end
      checks++; if (bus.dn_data[15:8] !== 8'h61) begin errors++; $display("FAIL skip_held_data got %h expected 61", bus.dn_data[15:8]); end
      bus.up_data = 8'hA1;
      step();
      checks++; if (bus.dn_valid !== 4'b1010) begin errors++; $display("FAIL skip_a1_valid got %b expected 1010", bus.dn_valid); end
      checks++; if (bus.dn_data[31:24] !== 8'hA1) begin errors++; $display("FAIL skip_a1_data got %h expected a1", bus.dn_data[31:24]); end
      bus.up_valid = 1'b0; bus.dn_ready = 4'b1111;
      step();
      checks++; if (bus.dn_valid !== 4'b0000) begin errors++; $display("FAIL skip_drain got %b expected 0000", bus.dn_valid); end
   endtask

   task automatic test_multi_beat();
      bus.up_valid = 1'b1; bus.up_data = 8'hB0; bus.up_last = 1'b0; bus.dn_ready = 4'b1111;
      #1;
      checks++; if (bus.up_ready !== 1'b1) begin errors++; $display("FAIL multi_b0_ready got %b expected 1", bus.up_ready); end
      step();
      checks++; if (bus.dn_valid !== 4'b0001) begin errors++; $display("FAIL multi_b0_valid got %b expected 0001", bus.dn_valid); end
      checks++; if (bus.dn_data[7:0] !== 8'hB0) begin errors++; $display("FAIL multi_b0_data got %h expected b0", bus.dn_data[7:0]); end
      checks++; if (bus.dn_last[0] !== 1'b0) begin errors++; $display("FAIL multi_b0_last got %b expected 0", bus.dn_last[0]); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL multi_busy got %b expected 1", bus.busy); end
      bus.up_data = 8'hB1; bus.dn_ready = 4'b1110;
      #1;
      checks++; if (bus.up_ready !== 1'b0) begin errors++; $display("FAIL multi_stall_ready got %b expected 0", bus.up_ready); end
      step();
      checks++; if (bus.dn_valid !== 4'b0001) begin errors++; $display("FAIL multi_stall_valid got %b expected 0001", bus.dn_valid); end
      checks++; if (bus.dn_data[7:0] !== 8'hB0) begin errors++; $display("FAIL multi_stall_data got %h expected b0", bus.dn_data[7:0]); end
      bus.dn_ready = 4'b1111;
      #1;
      checks++; if (bus.up_ready !== 1'b1) begin errors++; $display("FAIL multi_b1_ready got %b expected 1", bus.up_ready); end
      step();
      checks++; if (bus.dn_data[7:0] !== 8'hB1) begin errors++; $display("FAIL multi_b1_data got %h expected b1", bus.dn_data[7:0]); end
      checks++; if (bus.dn_valid !== 4'b0001) begin errors++; $display("FAIL multi_b1_valid got %b expected 0001", bus.dn_valid); end
      bus.up_data = 8'hB2; bus.up_last = 1'b1;
      step();
      checks++; if (bus.dn_data[7:0] !== 8'hB2) begin errors++; $display("FAIL multi_b2_data got %h expected b2", bus.dn_data[7:0]); end
      checks++; if (bus.dn_last[0] !== 1'b1) begin errors++; $display("FAIL multi_b2_last got %b expected 1", bus.dn_last[0]); end
      bus.up_valid = 1'b0;
      step();
      checks++; if (dut.token_q !== 4'b0010) begin errors++; $display("FAIL multi_token got %b expected 0010", dut.token_q); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL multi_idle_busy got %b expected 0", bus.busy); end
   endtask

   task automatic test_refill();
      bus.port_enable = 4'b0100; bus.dn_ready = 4'b1111;
      bus.up_valid = 1'b1; bus.up_data = 8'hC4; bus.up_last = 1'b1;
      step();
      checks++; if (bus.dn_valid !== 4'b0100) begin errors++; $display("FAIL refill_c4_valid got %b expected 0100", bus.dn_valid); end
      checks++; if (bus.dn_data[23:16] !== 8'hC4) begin errors++; $display("FAIL refill_c4_data got %h expected c4", bus.dn_data[23:16]); end
      bus.up_data = 8'hC5;
      #1;
      checks++; if (bus.up_ready !== 1'b1) begin errors++; $display("FAIL refill_ready got %b expected 1", bus.up_ready); end
      step();
      checks++; if (bus.dn_valid !== 4'b0100) begin errors++; $display("FAIL refill_c5_valid got %b expected 0100", bus.dn_valid); end
      checks++; if (bus.dn_data[23:16] !== 8'hC5) begin errors++; $display("FAIL refill_c5_data got %h expected c5", bus.dn_data[23:16]); end
      bus.up_valid = 1'b0;
      step();
      checks++; if (bus.dn_valid !== 4'b0000) begin errors++; $display("FAIL refill_drain got %b expected 0000", bus.dn_valid); end
   endtask

   task automatic test_disabled();
      bus.port_enable = 4'b0000;
      bus.up_valid = 1'b1; bus.up_data = 8'hEE; bus.up_last = 1'b1;
      #1;
      checks++; if (bus.up_ready !== 1'b0) begin errors++; $display("FAIL disabled_ready got %b expected 0", bus.up_ready); end
      step();
      checks++; if (bus.dn_valid !== 4'b0000) begin errors++; $display("FAIL disabled_valid got %b expected 0000", bus.dn_valid); end
      checks++; if (dut.token_q !== 4'b1000) begin errors++; $display("FAIL disabled_token got %b expected 1000", dut.token_q); end
      bus.up_valid = 1'b0;
   endtask

   task automatic test_enable_single();
      bus.port_enable = 4'b1111;
      bus.up_valid = 1'b1; bus.up_data = 8'hD3; bus.up_last = 1'b1;
      step();
      checks++; if (bus.dn_valid !== 4'b1000) begin errors++; $display("FAIL enable_d3_valid got %b expected 1000", bus.dn_valid); end
      bus.port_enable = 4'b0100; bus.up_data = 8'hD2;
      #1;
      checks++; if (bus.up_ready !== 1'b1) begin errors++; $display("FAIL enable_ready got %b expected 1", bus.up_ready); end
      step();
      checks++; if (bus.dn_valid !== 4'b0100) begin errors++; $display("FAIL enable_d2_valid got %b expected 0100", bus.dn_valid); end
      checks++; if (bus.dn_data[23:16] !== 8'hD2) begin errors++; $display("FAIL enable_d2_data got %h expected d2", bus.dn_data[23:16]); end
      bus.up_valid = 1'b0;
      step();
   endtask

   task automatic test_reset_mid();
      bus.port_enable = 4'b1111; bus.dn_ready = 4'b1111;
      bus.up_valid = 1'b1; bus.up_data = 8'hE0; bus.up_last = 1'b0;
      step();
      checks++; if (bus.dn_valid !== 4'b1000) begin errors++; $display("FAIL rstmid_e0_valid got %b expected 1000", bus.dn_valid); end
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL rstmid_busy_pre got %b expected 1", bus.busy); end
      bus.up_data = 8'hE1; bus.dn_ready = 4'b0000;
      rst = 1'b1;
      step();
      rst = 1'b0;
      checks++; if (bus.dn_valid !== 4'b0000) begin errors++; $display("FAIL rstmid_valid got %b expected 0000", bus.dn_valid); end
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b expected 0", bus.busy); end
      checks++; if (dut.token_q !== 4'b0001) begin errors++; $display("FAIL rstmid_token got %b expected 0001", dut.token_q); end
      bus.up_data = 8'hF0; bus.up_last = 1'b1; bus.dn_ready = 4'b1111;
      step();
      checks++; if (bus.dn_valid !== 4'b0001) begin errors++; $display("FAIL rstmid_f0_valid got %b expected 0001", bus.dn_valid); end
      checks++; if (bus.dn_data[7:0] !== 8'hF0) begin errors++; $display("FAIL rstmid_f0_data got %h expected f0", bus.dn_data[7:0]); end
      bus.up_valid = 1'b0;
      step();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_single_beat();
      test_skip_held();
      test_multi_beat();
      test_refill();
      test_disabled();
      test_enable_single();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
